// File: rtl/bk_divider.sv
// Sequential radix-2 restoring divider; one Brent-Kung trial subtraction per cycle.
// Optional macro BK_DIV_SIGNED_EN selects two's-complement operands (magnitude divide + sign fix-up).
module bk_divider #(
  parameter int unsigned nLayer = 5,
  localparam int unsigned N = 2 ** (nLayer - 1)
) (
  input  logic         inp_clk,
  input  logic         inp_rst,
  input  logic         inp_start,
  input  logic [N-1:0] inp_dividend,
  input  logic [N-1:0] inp_divisor,
  output logic         out_busy,
  output logic         out_done,
  output logic [N-1:0] out_quotient,
  output logic [N-1:0] out_remainder,
  output logic         out_div_by_zero
);

  localparam int unsigned W  = N + 1;
  localparam int unsigned CW = (nLayer > 1) ? nLayer - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic [N-1:0]   dv_q, dv_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
`ifdef BK_DIV_SIGNED_EN
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
`endif

  logic [W-1:0]   shifted;
  logic [N-1:0]   trial;
  logic           no_borrow;
  logic [N-1:0]   r_next;
  logic [N-1:0]   q_next;

  assign shifted = {r_q, q_q[N-1]};

  // Brent-Kung prefix carry network computing shifted - {0,D}; carry-in is 1
  always_comb begin : prefix_sub
    logic [W-1:0] b_op;
    logic [W-1:0] pg;
    logic [W-1:0] gg;
    logic [W-1:0] pp;
    int           d;
    b_op  = ~{1'b0, dv_q};
    pg    = shifted ^ b_op;
    gg    = shifted & b_op;
    pp    = pg;
    gg[0] = gg[0] | pg[0];
    for (int lvl = 0; lvl < int'(nLayer); lvl++) begin
      d = 1 << lvl;
      for (int i = 0; i < int'(W); i++) begin
        if (((i + 1) % (2 * d)) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i-d]);
          pp[i] = pp[i] & pp[i-d];
        end
      end
    end
    for (int lvl = int'(nLayer) - 2; lvl >= 0; lvl--) begin
      d = 1 << lvl;
      for (int i = 0; i < int'(W); i++) begin
        if (i >= 2 * d && ((i + 1) % (2 * d)) == d) begin
          gg[i] = gg[i] | (pp[i] & gg[i-d]);
          pp[i] = pp[i] & pp[i-d];
        end
      end
    end
    trial     = pg[N-1:0] ^ {gg[N-2:0], 1'b1};
    no_borrow = gg[W-1];
  end

  assign r_next = no_borrow ? trial : shifted[N-1:0];
  assign q_next = {q_q[N-2:0], no_borrow};

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dv_d    = dv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef BK_DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (inp_start) begin
          cnt_d = '0;
          r_d   = '0;
`ifdef BK_DIV_SIGNED_EN
          q_d    = inp_dividend[N-1] ? N'(-inp_dividend) : inp_dividend;
          dv_d   = inp_divisor[N-1] ? N'(-inp_divisor) : inp_divisor;
          qneg_d = inp_dividend[N-1] ^ inp_divisor[N-1];
          rneg_d = inp_dividend[N-1];
`else
          q_d  = inp_dividend;
          dv_d = inp_divisor;
`endif
          if (inp_divisor == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            quot_d  = '1;
            rem_d   = inp_dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      S_CALC: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = 1'b0;
`ifdef BK_DIV_SIGNED_EN
          quot_d = qneg_q ? N'(-q_next) : q_next;
          rem_d  = rneg_q ? N'(-r_next) : r_next;
`else
          quot_d = q_next;
          rem_d  = r_next;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dv_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef BK_DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef BK_DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign out_busy        = busy_q;
  assign out_done        = done_q;
  assign out_quotient    = quot_q;
  assign out_remainder   = rem_q;
  assign out_div_by_zero = dbz_q;

endmodule

// File: tb/tb_bk_divider.sv
// Self-checking bench for bk_divider: directed spec vectors plus randomized ops against an arithmetic model.
module tb_bk_divider;
  localparam int unsigned NL = 5;
  localparam int unsigned N  = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dvd;
  logic [N-1:0] dvs;
  logic         busy;
  logic         done;
  logic [N-1:0] quo;
  logic [N-1:0] rem;
  logic         dbz;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bk_divider #(.nLayer(NL)) dut (
    .inp_clk        (clk),
    .inp_rst        (rst),
    .inp_start      (start),
    .inp_dividend   (dvd),
    .inp_divisor    (dvs),
    .out_busy       (busy),
    .out_done       (done),
    .out_quotient   (quo),
    .out_remainder  (rem),
    .out_div_by_zero(dbz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division; signed build divides magnitudes and truncates toward zero
  function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z);
`ifdef BK_DIV_SIGNED_EN
    logic [N-1:0] ma, mb, mq, mr;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef BK_DIV_SIGNED_EN
      ma = a[N-1] ? N'(-a) : a;
      mb = b[N-1] ? N'(-b) : b;
      mq = ma / mb;
      mr = ma % mb;
      q  = (a[N-1] ^ b[N-1]) ? N'(-mq) : mq;
      r  = a[N-1] ? N'(-mr) : mr;
`else
      q = a / b;
      r = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // Issues one start and waits for done; lat counts cycles after the accept edge
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int lat,
                        output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic z, output logic busy_seen);
    start = 1'b1;
    dvd   = a;
    dvs   = b;
    tick();
    start = 1'b0;
    dvd   = N'($urandom);
    dvs   = N'($urandom);
    busy_seen = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 4 * int'(N)) begin
      tick();
      lat++;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    q = quo;
    r = rem;
    z = dbz;
  endtask

  task automatic check_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
    int lat;
    logic [N-1:0] q, r, eq, er;
    logic z, ez, bs;
    int exp_lat;
    ref_div(a, b, eq, er, ez);
    exp_lat = (b == '0) ? 0 : int'(N);
    run_op(a, b, lat, q, r, z, bs);
    n_checks++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d (a=%h b=%h)", name, lat, exp_lat, a, b);
    else n_pass++;
    n_checks++;
    if (q !== eq) $display("FAIL %s quotient: got %h want %h (a=%h b=%h)", name, q, eq, a, b);
    else n_pass++;
    n_checks++;
    if (r !== er) $display("FAIL %s remainder: got %h want %h (a=%h b=%h)", name, r, er, a, b);
    else n_pass++;
    n_checks++;
    if (z !== ez) $display("FAIL %s div_by_zero: got %b want %b (a=%h b=%h)", name, z, ez, a, b);
    else n_pass++;
    n_checks++;
    if (bs !== (b != '0)) $display("FAIL %s busy_seen: got %b want %b", name, bs, (b != '0));
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL %s done_one_cycle: got %b want 0", name, done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, dbz} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, dbz});
    else n_pass++;
    n_checks++;
    if ({quo, rem} !== '0) $display("FAIL reset_results: got %h/%h want 0/0", quo, rem);
    else n_pass++;
  endtask

  task automatic test_basic();
    check_op("d100_7", 16'd100, 16'd7);
    check_op("ffff_1", 16'hFFFF, 16'h0001);
    check_op("3_ffff", 16'h0003, 16'hFFFF);
  endtask

  task automatic test_div_by_zero();
    check_op("dbz_5_0", 16'd5, 16'd0);
    check_op("after_dbz_9_3", 16'd9, 16'd3);
    start = 1'b1;
    dvd = 16'd7;
    dvs = 16'd0;
    tick();
    n_checks++;
    if ({done, dbz, rem} !== {1'b1, 1'b1, 16'd7}) $display("FAIL dbz_b2b_first: got %b%b %h want 11 0007", done, dbz, rem);
    else n_pass++;
    dvd = 16'd8;
    tick();
    start = 1'b0;
    n_checks++;
    if ({done, dbz, rem, busy} !== {1'b1, 1'b1, 16'd8, 1'b0}) $display("FAIL dbz_b2b_second: got %b%b %h %b want 11 0008 0", done, dbz, rem, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL dbz_b2b_end: got %b want 0", done);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    int ndone, elapsed, done_at;
    logic [N-1:0] q, r;
    start = 1'b1;
    dvd = 16'd1000;
    dvs = 16'd10;
    tick();
    start = 1'b0;
    ndone = 0;
    done_at = -1;
    q = '0;
    r = '0;
    for (elapsed = 0; elapsed < 3 * int'(N); elapsed++) begin
      if (elapsed == 5) begin
        start = 1'b1;
        dvd = 16'd1;
        dvs = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        done_at = elapsed;
        q = quo;
        r = rem;
      end
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (ndone !== 1) $display("FAIL ignored_start_done_count: got %0d want 1", ndone);
    else n_pass++;
    n_checks++;
    if (done_at !== int'(N)) $display("FAIL ignored_start_latency: got %0d want %0d", done_at, N);
    else n_pass++;
    n_checks++;
    if ({q, r} !== {16'd100, 16'd0}) $display("FAIL ignored_start_result: got %0d r %0d want 100 r 0", q, r);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ndone;
    start = 1'b1;
    dvd = 16'd500;
    dvs = 16'd3;
    tick();
    start = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_mid_busy_before: got %b want 1", busy);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, dbz, quo, rem} !== '0) $display("FAIL reset_mid_outputs: got %b%b%b %h %h want all 0", busy, done, dbz, quo, rem);
    else n_pass++;
    ndone = 0;
    repeat (2 * N) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone !== 0) $display("FAIL reset_mid_no_done: got %0d dones want 0", ndone);
    else n_pass++;
    check_op("after_reset_500_3", 16'd500, 16'd3);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [N-1:0] a1, b1, a2, b2, eq, er;
    logic ez;
    a1 = N'($urandom);
    b1 = N'($urandom_range(1, 300));
    a2 = N'($urandom);
    b2 = N'($urandom_range(1, 65535));
    start = 1'b1;
    dvd = a1;
    dvs = b1;
    tick();
    dvd = a2;
    dvs = b2;
    lat = 0;
    while (done !== 1'b1 && lat < 4 * int'(N)) begin
      tick();
      lat++;
    end
    ref_div(a1, b1, eq, er, ez);
    n_checks++;
    if (lat !== int'(N) || quo !== eq || rem !== er) $display("FAIL b2b_first: lat %0d q %h r %h want lat %0d q %h r %h", lat, quo, rem, N, eq, er);
    else n_pass++;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b10) $display("FAIL b2b_accept: busy/done got %b want 10", {busy, done});
    else n_pass++;
    lat = 0;
    while (done !== 1'b1 && lat < 4 * int'(N)) begin
      tick();
      lat++;
    end
    ref_div(a2, b2, eq, er, ez);
    n_checks++;
    if (lat !== int'(N) || quo !== eq || rem !== er) $display("FAIL b2b_second: lat %0d q %h r %h want lat %0d q %h r %h", lat, quo, rem, N, eq, er);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    for (int k = 0; k < 40; k++) begin
      a = N'($urandom);
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = N'($urandom_range(1, 15));
        2: b = N'($urandom);
        default: b = N'($urandom >> $urandom_range(16, 31));
      endcase
      check_op($sformatf("rand%0d", k), a, b);
    end
  endtask

`ifdef BK_DIV_SIGNED_EN
  task automatic test_signed();
    check_op("s_m7_2", 16'hFFF9, 16'h0002);
    check_op("s_ovf", 16'h8000, 16'hFFFF);
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dvd = '0;
    dvs = '0;
    test_reset();
    test_basic();
    test_div_by_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
`ifdef BK_DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
